// File: rtl/shrv_iter_ctrl.sv
// Multi-cycle variable right shifter: repeats a fixed stepbits shift (then single-bit steps)
// on a held register until the clamped amount is consumed; result held until out_ready.
module shrv_iter_ctrl #(
  parameter int width    = 8,
  parameter int stepbits = 2,
  parameter int amtbits  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic               pred,
  input  logic [amtbits-1:0] amt,
  input  logic [width-1:0]   i0,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               o0_enable,
  output logic [width-1:0]   o0,
  output logic               busy
);

  localparam int RW = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [RW-1:0]   rem;
  logic            op_q;

  logic [31:0]     amt_w;
  logic [RW-1:0]   amt_clamp;
  logic            take_big;
  logic [RW-1:0]   rem_next;
  logic [width-1:0] o0_next;

  assign in_ready = (state == IDLE) & ~reset;
  assign busy     = (state != IDLE);

  always_comb begin
    amt_w     = 32'(amt);
    amt_clamp = (amt_w >= 32'(width)) ? RW'(width) : RW'(amt_w);
  end

  // Coarse step while enough amount remains, then finish with single-bit steps.
  always_comb begin
    take_big = (32'(rem) >= 32'(stepbits));
    o0_next  = o0;
    if (take_big) begin
      if (op_q) o0_next = width'($signed(o0) >>> stepbits);
      else      o0_next = o0 >> stepbits;
      rem_next = rem - RW'(stepbits);
    end else begin
      if (op_q) o0_next = width'($signed(o0) >>> 1);
      else      o0_next = o0 >> 1;
      rem_next = rem - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      o0        <= '0;
      o0_enable <= 1'b0;
      out_valid <= 1'b0;
      rem       <= '0;
      op_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            o0        <= i0;
            op_q      <= op;
            o0_enable <= pred;
            rem       <= amt_clamp;
            if (!pred || amt_clamp == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          o0  <= o0_next;
          rem <= rem_next;
          if (rem_next == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shrv_iter_ctrl.sv
// Directed bench for shrv_iter_ctrl (width 8, stepbits 2, amtbits 4).
module tb_shrv_iter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic       pred;
  logic [3:0] amt;
  logic [7:0] i0;
  logic       out_valid;
  logic       out_ready;
  logic       o0_enable;
  logic [7:0] o0;
  logic       busy;

  int asserts  = 0;
  int failures = 0;

  shrv_iter_ctrl #(.width(8), .stepbits(2), .amtbits(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .pred(pred), .amt(amt), .i0(i0),
    .out_valid(out_valid), .out_ready(out_ready),
    .o0_enable(o0_enable), .o0(o0), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one request; returns at the falling edge one cycle after the accept edge.
  task automatic send(input logic [7:0] d, input logic [3:0] a, input logic o, input logic p);
    @(negedge clk);
    in_valid = 1'b1; i0 = d; amt = a; op = o; pred = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles since the accept edge until out_valid (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 1'b0; pred = 1'b0; amt = '0; i0 = '0;
    repeat (3) @(negedge clk);
    asserts++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    asserts++; if (o0 !== 8'h00) begin failures++; $display("FAIL reset_o0 got %h want 00", o0); end
    asserts++; if (o0_enable !== 1'b0) begin failures++; $display("FAIL reset_o0_enable got %b want 0", o0_enable); end
    asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
    reset = 1'b0;
    #1;
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_logical;
    int lat;
    send(8'hB4, 4'd5, 1'b0, 1'b1);
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL logical_busy got %b want 1", busy); end
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL logical_in_ready got %b want 0", in_ready); end
    wait_valid(lat);
    asserts++; if (lat !== 4) begin failures++; $display("FAIL logical_latency got %0d want 4", lat); end
    asserts++; if (o0 !== 8'h05) begin failures++; $display("FAIL logical_o0 got %h want 05", o0); end
    asserts++; if (o0_enable !== 1'b1) begin failures++; $display("FAIL logical_en got %b want 1", o0_enable); end
    handshake();
    asserts++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL logical_release got v=%b b=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_arith;
    int lat;
    send(8'h90, 4'd3, 1'b1, 1'b1);
    wait_valid(lat);
    asserts++; if (lat !== 3) begin failures++; $display("FAIL arith_latency got %0d want 3", lat); end
    asserts++; if (o0 !== 8'hF2) begin failures++; $display("FAIL arith_o0 got %h want F2", o0); end
    handshake();
  endtask

  task automatic test_zero_squash;
    int lat;
    send(8'h3C, 4'd0, 1'b1, 1'b1);
    wait_valid(lat);
    asserts++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got %0d want 1", lat); end
    asserts++; if (o0 !== 8'h3C) begin failures++; $display("FAIL zero_o0 got %h want 3C", o0); end
    handshake();
    send(8'hAA, 4'd7, 1'b0, 1'b0);
    wait_valid(lat);
    asserts++; if (lat !== 1) begin failures++; $display("FAIL squash_latency got %0d want 1", lat); end
    asserts++; if (o0 !== 8'hAA) begin failures++; $display("FAIL squash_o0 got %h want AA", o0); end
    asserts++; if (o0_enable !== 1'b0) begin failures++; $display("FAIL squash_en got %b want 0", o0_enable); end
    handshake();
  endtask

  task automatic test_saturation;
    int lat;
    send(8'h80, 4'd15, 1'b1, 1'b1);
    wait_valid(lat);
    asserts++; if (lat !== 5) begin failures++; $display("FAIL sat_arith_latency got %0d want 5", lat); end
    asserts++; if (o0 !== 8'hFF) begin failures++; $display("FAIL sat_arith_o0 got %h want FF", o0); end
    handshake();
    send(8'h80, 4'd15, 1'b0, 1'b1);
    wait_valid(lat);
    asserts++; if (lat !== 5) begin failures++; $display("FAIL sat_logical_latency got %0d want 5", lat); end
    asserts++; if (o0 !== 8'h00) begin failures++; $display("FAIL sat_logical_o0 got %h want 00", o0); end
    handshake();
  endtask

  task automatic test_back_to_back;
    int lat;
    send(8'h0F, 4'd2, 1'b0, 1'b1);
    wait_valid(lat);
    asserts++; if (lat !== 2) begin failures++; $display("FAIL bp_first_latency got %0d want 2", lat); end
    in_valid = 1'b1; i0 = 8'h55; amt = 4'd1; op = 1'b0; pred = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      asserts++;
      if (out_valid !== 1'b1 || o0 !== 8'h03 || o0_enable !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got v=%b o0=%h en=%b rdy=%b want 1 03 1 0", k, out_valid, o0, o0_enable, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    asserts++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_after_handshake got rdy=%b v=%b want 1 0", in_ready, out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept got busy=%b want 1", busy); end
    wait_valid(lat);
    asserts++; if (lat !== 2) begin failures++; $display("FAIL bp_second_latency got %0d want 2", lat); end
    asserts++; if (o0 !== 8'h2A) begin failures++; $display("FAIL bp_second_o0 got %h want 2A", o0); end
    handshake();
  endtask

  task automatic test_reset_mid;
    int seen;
    send(8'hFF, 4'd7, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    asserts++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    asserts++;
    if (out_valid !== 1'b0 || o0 !== 8'h00 || o0_enable !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state got v=%b o0=%h en=%b busy=%b want 0 00 0 0", out_valid, o0, o0_enable, busy);
    end
    reset = 1'b0;
    #1;
    asserts++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready_after got %b want 1", in_ready); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    asserts++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_output got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_squash();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/shrv_iter_ctrl.md
Name: shrv_iter_ctrl

Overview:
Multi-cycle variable-amount right shifter built around fixed-step shift stages. A small state machine schedules repeated constant shifts on one held data register until the requested amount has been applied. It gives the datapath a variable shift (logical or arithmetic) without a full barrel shifter. It sits beside the constant-shift macrocells and keeps their op/pred semantics: op 0 = logical, op 1 = arithmetic, and pred gates o0_enable.

Parameters:
width, 8, data width in bits (>= 2)
stepbits, 2, coarse shift per iteration (1 <= stepbits <= width)
amtbits, 4, width of the shift-amount input (2^amtbits - 1 may exceed width)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
op  in  1  0 logical shift, 1 arithmetic shift; sampled on accept
pred  in  1  predicate; sampled on accept
amt  in  amtbits  shift amount, unsigned; sampled on accept
i0  in  width  operand; sampled on accept
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
o0_enable  out  1  registered copy of the accepted pred
o0  out  width  result register
busy  out  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, o0 = 0, o0_enable = 0, out_valid = 0, internal rem = 0, op_q = 0.
- Reset dominates every other input in the same cycle. Reset asserted mid-SHIFT or in DONE aborts the operation with no output.
- in_ready = (state == IDLE) & ~reset. busy = (state != IDLE).
- States:
  - IDLE: accept when in_valid & in_ready. On accept:
    - o0 <= i0; op_q <= op; o0_enable <= pred.
    - rem <= min(amt, width). Amounts >= width saturate to width, so the result is all sign bits (op=1) or zero (op=0).
    - Next state: if pred == 0 or the clamped amt == 0, go to DONE (o0 = i0 unchanged). Otherwise go to SHIFT.
  - SHIFT: one step per cycle.
    - If rem >= stepbits: shift o0 right by stepbits and set rem -= stepbits.
    - Otherwise: shift o0 right by 1 and set rem -= 1.
    - Fill bits are o0[width-1] when op_q = 1, and 0 when op_q = 0.
    - When the updated rem == 0, go to DONE.
  - DONE: out_valid = 1. o0 and o0_enable stay stable until out_ready is high. On out_valid & out_ready, go to IDLE and clear out_valid in the same edge.
- No new request is accepted in DONE. Back-to-back throughput is one request per (steps + 2) cycles.
- Latency from the accept edge to out_valid = steps + 1 cycles, where steps = floor(a/stepbits) + (a mod stepbits) and a = clamped amt.
  - If pred = 0 or a = 0, steps = 0, so out_valid appears 1 cycle after accept.
- In IDLE, out_ready is ignored. In SHIFT and DONE, in_valid is ignored; in_ready = 0 means the requester must hold.
- pred = 0: o0 = i0 is still returned with out_valid, and o0_enable = 0. The consumer uses o0_enable to squash the write.
- Arithmetic: no widening beyond width. The sign bit is the current o0 MSB, which equals the original i0 MSB under arithmetic shift.

Test Plan:
1. Logical: width 8, stepbits 2, i0 = 0xB4, amt = 5, op = 0, pred = 1 -> steps 2,2,1; out_valid 4 cycles after accept; o0 = 0x05; o0_enable = 1.
2. Arithmetic: i0 = 0x90, amt = 3, op = 1 -> steps 2,1; out_valid 3 cycles after accept; o0 = 0xF2.
3. Zero and squash:
   - amt = 0, i0 = 0x3C -> o0 = 0x3C with out_valid 1 cycle after accept.
   - pred = 0, amt = 7, i0 = 0xAA -> o0 = 0xAA, o0_enable = 0, out_valid 1 cycle after accept, no SHIFT cycles.
4. Saturation: amt = 15, i0 = 0x80 -> op = 1 gives o0 = 0xFF; op = 0 gives o0 = 0x00; both after 4 SHIFT cycles (out_valid 5 cycles after accept).
5. Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new data -> o0, o0_enable and out_valid stable; in_ready = 0; the new request is accepted only in the cycle after the out_ready handshake.
6. Reset mid-operation: assert reset during the 2nd SHIFT cycle of amt = 7 -> next cycle state IDLE, out_valid = 0, o0 = 0, o0_enable = 0; in_ready = 1 once reset deasserts; no result is emitted.
